music_player: RTL and testbench

- Playback controller and speaker driver on the consuming side of the beat-indexed tone tables (e.g. the win tune).
- Steps a quarter-beat index `beat_num` at a fixed tempo and feeds it to a tone table.
- Takes back the table's combinational 32-bit frequency in Hz (`tone_in`) and turns it into a 50%-duty square wave for the buzzer/audio pin.
- Handles start, stop, looping and end-of-song signalling.

---
 rtl/music_player.sv | 141 ++++++++++++++
 tb/tb_music_player.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/music_player.sv
// music_player
//   Playback controller and speaker driver for a beat-indexed tone table.
//   Steps a quarter-beat index at a fixed tempo and presents it to an external
//   tone table. The table's combinational frequency (Hz) comes back on tone_in
//   and is turned into a 50%-duty square wave. A phase accumulator is used, so
//   no divider is needed.
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   begin playback from beat 0 (ignored while playing)
//   stop       in   abort playback and return to idle (wins over start)
//   loop_en    in   at the end of the song: 1 = wrap to beat 0, 0 = finish
//   tone_in    in   [31:0] frequency in Hz for the current beat_num
//   beat_num   out  [BEAT_W-1:0] current quarter-beat index (registered)
//   playing    out  high while in PLAY
//   done       out  one-cycle pulse when a non-looping song ends
//   audio_out  out  square-wave speaker drive (registered)
module music_player #(
  parameter int CLK_FREQ  = 100000000,
  parameter int BEAT_FREQ = 8,
  parameter int LAST_BEAT = 296,
  parameter int BEAT_W    = 10,
  parameter int SILENT_TH = 20000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [31:0]       tone_in,
  output logic [BEAT_W-1:0] beat_num,
  output logic              playing,
  output logic              done,
  output logic              audio_out
);

  localparam int BEAT_CYC = CLK_FREQ / BEAT_FREQ;
  localparam int TICK_MAX = BEAT_CYC - 1;
  localparam int CNT_W    = (BEAT_CYC > 1) ? $clog2(BEAT_CYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  logic [CNT_W-1:0]  tick_cnt_reg;
  logic [BEAT_W-1:0] beat_reg;
  logic [33:0]       acc_reg;
  logic              audio_reg;
  logic              done_reg;

  logic              tick;
  logic              at_last;
  logic              rest;
  logic [33:0]       sum;

  assign tick    = (state_reg == S_PLAY) && (tick_cnt_reg == CNT_W'(TICK_MAX));
  assign at_last = (beat_reg == BEAT_W'(LAST_BEAT));
  assign rest    = (tone_in == 32'd0) || (tone_in >= 32'(SILENT_TH));
  // Two half-periods per cycle of tone: add 2*tone each clock, toggle per CLK_FREQ.
  assign sum     = acc_reg + {1'b0, tone_in, 1'b0};

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start && !stop) state_next = S_PLAY;
      end
      S_PLAY: begin
        if (stop)                             state_next = S_IDLE;
        else if (tick && at_last && !loop_en) state_next = S_DONE;
      end
      S_DONE: begin
        if (stop)       state_next = S_IDLE;
        else if (start) state_next = S_PLAY;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Tempo counter, beat index, phase accumulator and audio register
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_reg <= '0;
      beat_reg     <= '0;
      acc_reg      <= '0;
      audio_reg    <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= (state_reg == S_PLAY) && (state_next == S_DONE);
      if (state_reg != S_PLAY || state_next != S_PLAY) begin
        // Not continuing playback: silence and clear timing. DONE keeps the
        // final beat index, IDLE and a fresh PLAY start from beat 0.
        tick_cnt_reg <= '0;
        acc_reg      <= '0;
        audio_reg    <= 1'b0;
        if (state_next != S_DONE) beat_reg <= '0;
      end else if (tick) begin
        // Every quarter-beat restarts the waveform phase at low.
        tick_cnt_reg <= '0;
        acc_reg      <= '0;
        audio_reg    <= 1'b0;
        beat_reg     <= at_last ? '0 : beat_reg + BEAT_W'(1);
      end else begin
        tick_cnt_reg <= tick_cnt_reg + CNT_W'(1);
        if (rest) begin
          acc_reg   <= '0;
          audio_reg <= 1'b0;
        end else if (sum >= 34'(CLK_FREQ)) begin
          acc_reg   <= sum - 34'(CLK_FREQ);
          audio_reg <= ~audio_reg;
        end else begin
          acc_reg   <= sum;
        end
      end
    end
  end

  // Outputs, all derived from registers only
  always_comb begin
    playing   = (state_reg == S_PLAY);
    done      = done_reg;
    audio_out = audio_reg;
    beat_num  = beat_reg;
  end

endmodule

// File: tb/tb_music_player.sv
module tb_music_player;

  localparam int CLK_FREQ  = 1000;
  localparam int BEAT_FREQ = 10;
  localparam int LAST_BEAT = 3;
  localparam int BEAT_W    = 10;
  localparam int SILENT_TH = 20000;
  localparam int BEAT_LEN  = CLK_FREQ / BEAT_FREQ;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              loop_en = 1'b1;
  logic [31:0]       tone_in;
  logic [BEAT_W-1:0] beat_num;
  logic              playing;
  logic              done;
  logic              audio_out;

  int tab [4] = '{100, 100, 100, 100};
  int total = 0;
  int bad = 0;

  // The bench acts as the tone table, indexed by the DUT's beat number.
  assign tone_in = 32'(tab[beat_num[1:0]]);

  always #5 clk = ~clk;

  music_player #(
    .CLK_FREQ (CLK_FREQ),
    .BEAT_FREQ(BEAT_FREQ),
    .LAST_BEAT(LAST_BEAT),
    .BEAT_W   (BEAT_W),
    .SILENT_TH(SILENT_TH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .loop_en  (loop_en),
    .tone_in  (tone_in),
    .beat_num (beat_num),
    .playing  (playing),
    .done     (done),
    .audio_out(audio_out)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 play, 2 done. pos = clock edges elapsed in the current beat.
  int m_mode = 0;
  int m_beat = 0;
  int m_pos  = 0;
  bit m_done = 1'b0;
  bit m_valid = 1'b0;

  // After p accumulation steps of 2*tone the waveform has toggled
  // floor(p*2*tone/CLK_FREQ) times, starting low.
  function automatic int exp_audio(input int p, input int tone);
    if (tone == 0 || tone >= SILENT_TH) return 0;
    return ((p * 2 * tone) / CLK_FREQ) % 2;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_mode  <= 0;
      m_beat  <= 0;
      m_pos   <= 0;
      m_done  <= 1'b0;
      m_valid <= 1'b1;
    end else begin
      m_done <= 1'b0;
      case (m_mode)
        0: if (start && !stop) begin
             m_mode <= 1; m_beat <= 0; m_pos <= 0;
           end
        1: if (stop) begin
             m_mode <= 0; m_beat <= 0; m_pos <= 0;
           end else if (m_pos == BEAT_LEN - 1) begin
             m_pos <= 0;
             if (m_beat < LAST_BEAT) m_beat <= m_beat + 1;
             else if (loop_en)       m_beat <= 0;
             else begin
               m_mode <= 2; m_done <= 1'b1;
             end
           end else begin
             m_pos <= m_pos + 1;
           end
        default: if (stop) begin
             m_mode <= 0; m_beat <= 0; m_pos <= 0;
           end else if (start) begin
             m_mode <= 1; m_beat <= 0; m_pos <= 0;
           end
      endcase
    end
  end

  // Compare process: every cycle once the model has seen reset.
  always @(negedge clk) begin
    if (m_valid) begin
      check("cyc_playing", 32'(playing),   32'(m_mode == 1));
      check("cyc_beat",    32'(beat_num),  32'(m_beat));
      check("cyc_done",    32'(done),      32'(m_done));
      check("cyc_audio",   32'(audio_out),
            (m_mode == 1) ? 32'(exp_audio(m_pos, tab[m_beat])) : 32'd0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic run(input int n, output int toggles, output int dones);
    logic prev;
    prev = audio_out;
    toggles = 0;
    dones = 0;
    repeat (n) begin
      @(negedge clk);
      if (audio_out !== prev) toggles++;
      if (done) dones++;
      prev = audio_out;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  initial begin
    int tg;
    int dn;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_beat", 32'(beat_num), 0);
    check("rst_playing", 32'(playing), 0);
    check("rst_audio", 32'(audio_out), 0);
    check("rst_done", 32'(done), 0);

    // Test 1: tone 100 Hz, looping
    loop_en = 1'b1;
    pulse_start();
    $display("txn start: beat=%0d playing=%0d", beat_num, playing);
    check("t1_playing", 32'(playing), 1);
    run(5, tg, dn);
    check("t1_audio_hi_at5", 32'(audio_out), 1);
    run(5, tg, dn);
    check("t1_audio_lo_at10", 32'(audio_out), 0);
    run(89, tg, dn);
    check("t1_beat0_end", 32'(beat_num), 0);
    run(1, tg, dn);
    check("t1_beat1", 32'(beat_num), 1);
    check("t1_phase_reset", 32'(audio_out), 0);
    run(99, tg, dn);
    $display("txn beat1: toggles=%0d", tg);
    check("t1_toggles", 32'(tg), 19);
    run(201, tg, dn);
    $display("txn wrap: beat=%0d dones=%0d", beat_num, dn);
    check("t1_wrap_beat", 32'(beat_num), 0);
    check("t1_wrap_nodone", 32'(dn), 0);

    // Test 2: finish without looping
    loop_en = 1'b0;
    run(399, tg, dn);
    check("t2_last_beat", 32'(beat_num), 3);
    check("t2_still_play", 32'(playing), 1);
    run(1, tg, dn);
    $display("txn end: done=%0d playing=%0d beat=%0d", done, playing, beat_num);
    check("t2_done", 32'(done), 1);
    check("t2_playing", 32'(playing), 0);
    check("t2_beat_hold", 32'(beat_num), 3);
    check("t2_audio", 32'(audio_out), 0);
    run(1, tg, dn);
    check("t2_done_1cyc", 32'(done), 0);
    check("t2_beat_hold2", 32'(beat_num), 3);

    // Test 3: rests and a faster tone
    pulse_stop();
    check("t3_idle_beat", 32'(beat_num), 0);
    tab = '{20000, 250, 0, 100};
    pulse_start();
    run(99, tg, dn);
    $display("txn rest20000: toggles=%0d", tg);
    check("t3_rest_hi", 32'(tg), 0);
    run(1, tg, dn);
    run(2, tg, dn);
    check("t3_250_at2", 32'(audio_out), 1);
    run(97, tg, dn);
    $display("txn tone250: toggles=%0d", tg);
    check("t3_250_toggles", 32'(tg), 48);
    run(1, tg, dn);
    check("t3_beat2", 32'(beat_num), 2);
    run(50, tg, dn);
    check("t3_rest0", 32'(tg), 0);

    // Test 4: stop mid-beat, then start+stop together from idle
    pulse_stop();
    $display("txn stop: beat=%0d playing=%0d", beat_num, playing);
    check("t4_stop_playing", 32'(playing), 0);
    check("t4_stop_beat", 32'(beat_num), 0);
    start = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop = 1'b0;
    check("t4_both_idle", 32'(playing), 0);
    run(3, tg, dn);

    // Test 5: reset mid-beat with audio high, then a clean restart
    tab = '{100, 100, 100, 100};
    pulse_start();
    run(5, tg, dn);
    check("t5_audio_hi", 32'(audio_out), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    $display("txn rst: audio=%0d playing=%0d beat=%0d", audio_out, playing, beat_num);
    check("t5_rst_audio", 32'(audio_out), 0);
    check("t5_rst_playing", 32'(playing), 0);
    pulse_start();
    run(50, tg, dn);
    pulse_start();  // ignored while playing
    run(48, tg, dn);
    check("t5_beat0_full", 32'(beat_num), 0);
    run(1, tg, dn);
    check("t5_beat1", 32'(beat_num), 1);
    run(3, tg, dn);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
